// File: rtl/instr_fsm_if.sv
// Controller bus: instruction/start inputs plus all datapath control outputs.
// The slave modport is the controller's side; the master modport drives s/load/in.
interface instr_fsm_if;
  logic        s;
  logic        load;
  logic [15:0] in;
  logic        w;
  logic [2:0]  readnum;
  logic [2:0]  writenum;
  logic        write;
  logic [1:0]  vsel;
  logic        loada;
  logic        loadb;
  logic        loadc;
  logic        loads;
  logic        asel;
  logic        bsel;
  logic [1:0]  shift;
  logic [1:0]  ALUop;
  logic [15:0] sximm8;

  modport master (
    output s, load, in,
    input  w, readnum, writenum, write, vsel, loada, loadb, loadc, loads,
    input  asel, bsel, shift, ALUop, sximm8
  );

  modport slave (
    input  s, load, in,
    output w, readnum, writenum, write, vsel, loada, loadb, loadc, loads,
    output asel, bsel, shift, ALUop, sximm8
  );
endinterface

// File: rtl/instr_fsm.sv
// Instruction register plus Moore sequencer for a small MOV/ALU datapath.
// Outputs are registered from the state being entered, so they track the state exactly.
module instr_fsm (
  input logic        clk,
  input logic        reset,
  instr_fsm_if.slave bus
);

  typedef enum logic [2:0] {
    StWait, StDecode, StImm, StGetA, StGetB, StExec, StWb
  } state_e;

  localparam logic [4:0] OpMovImm = 5'b110_10;
  localparam logic [4:0] OpMovReg = 5'b110_00;
  localparam logic [4:0] OpAdd    = 5'b101_00;
  localparam logic [4:0] OpCmp    = 5'b101_01;
  localparam logic [4:0] OpAnd    = 5'b101_10;
  localparam logic [4:0] OpMvn    = 5'b101_11;

  state_e      r_state;
  logic [15:0] r_ir;
  logic        r_w, r_write, r_loada, r_loadb, r_loadc, r_loads, r_asel;
  logic [2:0]  r_readnum, r_writenum;
  logic [1:0]  r_vsel;

  logic [4:0] w_opc;
  logic [2:0] w_rn, w_rd, w_rm;

  assign w_opc = r_ir[15:11];
  assign w_rn  = r_ir[10:8];
  assign w_rd  = r_ir[7:5];
  assign w_rm  = r_ir[2:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= StWait;
      r_ir       <= 16'h0000;
      r_w        <= 1'b1;
      r_write    <= 1'b0;
      r_loada    <= 1'b0;
      r_loadb    <= 1'b0;
      r_loadc    <= 1'b0;
      r_loads    <= 1'b0;
      r_asel     <= 1'b0;
      r_readnum  <= 3'd0;
      r_writenum <= 3'd0;
      r_vsel     <= 2'b00;
    end else begin
      r_w        <= 1'b0;
      r_write    <= 1'b0;
      r_loada    <= 1'b0;
      r_loadb    <= 1'b0;
      r_loadc    <= 1'b0;
      r_loads    <= 1'b0;
      r_asel     <= 1'b0;
      r_readnum  <= 3'd0;
      r_writenum <= 3'd0;
      r_vsel     <= 2'b00;
      case (r_state)
        StWait: begin
          if (bus.load) r_ir <= bus.in;
          if (bus.s) begin
            r_state <= StDecode;
          end else begin
            r_state <= StWait;
            r_w     <= 1'b1;
          end
        end
        StDecode: begin
          case (w_opc)
            OpMovImm: begin
              r_state    <= StImm;
              r_writenum <= w_rn;
              r_vsel     <= 2'b10;
              r_write    <= 1'b1;
            end
            OpMovReg, OpMvn: begin
              r_state   <= StGetB;
              r_readnum <= w_rm;
              r_loadb   <= 1'b1;
            end
            OpAdd, OpCmp, OpAnd: begin
              r_state   <= StGetA;
              r_readnum <= w_rn;
              r_loada   <= 1'b1;
            end
            default: begin
              r_state <= StWait;
              r_w     <= 1'b1;
            end
          endcase
        end
        StGetA: begin
          r_state   <= StGetB;
          r_readnum <= w_rm;
          r_loadb   <= 1'b1;
        end
        StGetB: begin
          r_state <= StExec;
          if (w_opc == OpCmp) r_loads <= 1'b1;
          else                r_loadc <= 1'b1;
          // Single-operand ops pass B through the ALU with A forced to zero.
          r_asel  <= (w_opc == OpMovReg) || (w_opc == OpMvn);
        end
        StExec: begin
          if (w_opc == OpCmp) begin
            r_state <= StWait;
            r_w     <= 1'b1;
          end else begin
            r_state    <= StWb;
            r_writenum <= w_rd;
            r_write    <= 1'b1;
          end
        end
        default: begin
          r_state <= StWait;
          r_w     <= 1'b1;
        end
      endcase
    end
  end

  assign bus.w        = r_w;
  assign bus.readnum  = r_readnum;
  assign bus.writenum = r_writenum;
  assign bus.write    = r_write;
  assign bus.vsel     = r_vsel;
  assign bus.loada    = r_loada;
  assign bus.loadb    = r_loadb;
  assign bus.loadc    = r_loadc;
  assign bus.loads    = r_loads;
  assign bus.asel     = r_asel;
  assign bus.bsel     = 1'b0;
  assign bus.shift    = r_ir[4:3];
  assign bus.ALUop    = r_ir[12:11];
  assign bus.sximm8   = {{8{r_ir[7]}}, r_ir[7:0]};

endmodule

// File: tb/tb_instr_fsm.sv
// Directed bench for instr_fsm: hand-computed expectations checked with immediate asserts.
module tb_instr_fsm;
  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;

  instr_fsm_if u_if ();

  instr_fsm u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_ir(input logic [15:0] word);
    u_if.in   = word;
    u_if.load = 1'b1;
    tick();
    u_if.load = 1'b0;
  endtask

  // Leaves the FSM in DECODE.
  task automatic start();
    u_if.s = 1'b1;
    tick();
    u_if.s = 1'b0;
  endtask

  initial begin
    n_vec     = 0;
    n_err     = 0;
    reset     = 1'b1;
    u_if.s    = 1'b0;
    u_if.load = 1'b0;
    u_if.in   = 16'h0000;
    #2;
    check("rst_w", u_if.w, 1);
    check("rst_write", u_if.write, 0);
    check("rst_sximm8", u_if.sximm8, 16'h0000);
    @(negedge clk);
    reset = 1'b0;

    // MOV R0,#7
    load_ir(16'hD007);
    check("movi_sx", u_if.sximm8, 16'h0007);
    check("movi_idle", u_if.w, 1);
    start();
    check("movi_dec_w", u_if.w, 0);
    check("movi_dec_wr", u_if.write, 0);
    tick();
    check("movi_write", u_if.write, 1);
    check("movi_wnum", u_if.writenum, 0);
    check("movi_vsel", u_if.vsel, 2'b10);
    tick();
    check("movi_done_w", u_if.w, 1);
    check("movi_done_wr", u_if.write, 0);

    // MOV R1,#-2
    load_ir(16'hD1FE);
    check("movn_sx", u_if.sximm8, 16'hFFFE);
    start();
    tick();
    check("movn_wnum", u_if.writenum, 1);
    check("movn_write", u_if.write, 1);
    tick();
    check("movn_done", u_if.w, 1);

    // ADD R2,R1,R0
    load_ir(16'hA140);
    check("add_aluop", u_if.ALUop, 2'b00);
    start();
    tick();
    check("add_geta_rn", u_if.readnum, 1);
    check("add_geta_la", u_if.loada, 1);
    tick();
    check("add_getb_rm", u_if.readnum, 0);
    check("add_getb_lb", u_if.loadb, 1);
    check("add_getb_la", u_if.loada, 0);
    tick();
    check("add_exec_lc", u_if.loadc, 1);
    check("add_exec_asel", u_if.asel, 0);
    check("add_exec_w", u_if.w, 0);
    tick();
    check("add_wb_wnum", u_if.writenum, 2);
    check("add_wb_write", u_if.write, 1);
    check("add_wb_vsel", u_if.vsel, 2'b00);
    tick();
    check("add_done", u_if.w, 1);

    // CMP R1,R0
    load_ir(16'hA900);
    check("cmp_aluop", u_if.ALUop, 2'b01);
    start();
    tick();
    check("cmp_geta_wr", u_if.write, 0);
    tick();
    check("cmp_getb_wr", u_if.write, 0);
    tick();
    check("cmp_exec_ls", u_if.loads, 1);
    check("cmp_exec_lc", u_if.loadc, 0);
    check("cmp_exec_wr", u_if.write, 0);
    tick();
    check("cmp_done_w", u_if.w, 1);
    check("cmp_done_wr", u_if.write, 0);

    // MOV R3,R1,LSL
    load_ir(16'hC069);
    start();
    tick();
    check("movr_getb_rm", u_if.readnum, 1);
    check("movr_getb_lb", u_if.loadb, 1);
    tick();
    check("movr_exec_asel", u_if.asel, 1);
    check("movr_exec_lc", u_if.loadc, 1);
    check("movr_exec_sh", u_if.shift, 2'b01);
    tick();
    check("movr_wb_wnum", u_if.writenum, 3);
    check("movr_wb_write", u_if.write, 1);
    tick();
    check("movr_done", u_if.w, 1);

    // Undefined opcode
    load_ir(16'hE000);
    start();
    check("undef_dec_w", u_if.w, 0);
    tick();
    check("undef_back_w", u_if.w, 1);
    check("undef_wr", u_if.write, 0);

    // load while busy is ignored, then reset mid-instruction in GETA
    load_ir(16'hA140);
    start();
    u_if.in   = 16'hFFFF;
    u_if.load = 1'b1;
    tick();
    u_if.load = 1'b0;
    check("busy_load_ir", u_if.sximm8, 16'h0040);
    check("busy_geta_la", u_if.loada, 1);
    reset = 1'b1;
    #1;
    check("rst_geta_w", u_if.w, 1);
    check("rst_geta_wr", u_if.write, 0);
    check("rst_geta_la", u_if.loada, 0);
    check("rst_geta_ir", u_if.sximm8, 16'h0000);
    @(negedge clk);
    reset = 1'b0;
    tick();
    tick();
    check("post_rst_idle", u_if.w, 1);
    check("post_rst_wr", u_if.write, 0);

    // s held high restarts immediately after WAIT is re-entered
    u_if.s = 1'b1;
    tick();
    check("hold_dec1", u_if.w, 0);
    tick();
    check("hold_wait", u_if.w, 1);
    tick();
    check("hold_dec2", u_if.w, 0);
    u_if.s = 1'b0;
    tick();
    check("hold_end", u_if.w, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/instr_fsm.md
INSTR_FSM -- requirements
Module: instr_fsm

Interface
REQ-001 Parameters: none; all widths fixed (16-bit instruction, 3-bit register index).
REQ-002 clk  in  1  single clock; all state changes on posedge clk.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 s  in  1  start; sampled only in WAIT.
REQ-005 load  in  1  instruction-register load enable; honoured only in WAIT.
REQ-006 in  in  16  instruction word.
REQ-007 w  out  1  idle flag; high only in WAIT.
REQ-008 readnum  out  3  register-file read index.
REQ-009 writenum  out  3  register-file write index.
REQ-010 write  out  1  register-file write enable.
REQ-011 vsel  out  2  write-data select: 00 = C result, 10 = sximm8.
REQ-012 loada, loadb, loadc, loads  out  1 each  load enables for A, B, C and status registers.
REQ-013 asel, bsel  out  1 each  operand selects; asel=1 forces A operand to zero.
REQ-014 shift  out  2  shifter op, equal to IR[4:3].
REQ-015 ALUop  out  2  ALU op, equal to IR[12:11].
REQ-016 sximm8  out  16  IR[7:0] sign-extended to 16 bits (combinational).

Function
REQ-017 IR: 16-bit register; captures in on posedge when load=1 and state=WAIT; holds otherwise.
REQ-018 Decode fields: opcode=IR[15:13], op=IR[12:11], Rn=IR[10:8], Rd=IR[7:5], Rm=IR[2:0].
REQ-019 Supported instructions: MOV Rn,#imm8 (110/10); MOV Rd,Rm{,sh} (110/00); ADD (101/00); CMP (101/01); AND (101/10); MVN (101/11); all other opcode/op pairs are undefined.
REQ-020 Moore FSM, states WAIT, DECODE, IMM, GETA, GETB, EXEC, WB; each output is 0 unless asserted below.
REQ-021 WAIT: w=1; s=1 -> DECODE, else stay.
REQ-022 DECODE: MOV imm -> IMM; MOV reg or MVN -> GETB; ADD/CMP/AND -> GETA; undefined -> WAIT with no write.
REQ-023 IMM: writenum=Rn, vsel=10, write=1; -> WAIT.
REQ-024 GETA: readnum=Rn, loada=1; -> GETB.
REQ-025 GETB: readnum=Rm, loadb=1; -> EXEC.
REQ-026 EXEC: CMP asserts loads=1, then -> WAIT; all other instructions assert loadc=1, then -> WB; MOV reg and MVN also assert asel=1.
REQ-027 WB: writenum=Rd, vsel=00, write=1; -> WAIT.
REQ-028 Latency (posedge count from the edge sampling s=1 to return to WAIT): MOV imm 3; MOV reg/MVN 5; CMP 5; ADD/AND 6.
REQ-029 write is high for exactly one cycle per writing instruction; CMP and undefined instructions never assert write.
REQ-030 s is ignored outside WAIT; s held high starts the next instruction on the edge after WAIT is re-entered.

Reset
REQ-031 reset=1 forces state=WAIT and IR=0 immediately, without waiting for clk.
REQ-032 During reset, w=1 and every other output equals its WAIT value; an instruction in flight is aborted with no write.

Verification
REQ-033 Reset asserted in GETA -> w=1 in the same cycle; write stays 0; the FSM remains in WAIT after release until s=1.
REQ-034 IR=0xD007 (MOV R0,#7), s pulse -> one cycle with write=1, writenum=0, vsel=10, sximm8=0x0007; w=1 after 3 edges.
REQ-035 IR=0xD1FE (MOV R1,#-2) -> sximm8=0xFFFE, writenum=1.
REQ-036 IR=0xA140 (ADD R2,R1,R0) -> GETA readnum=1 loada=1; GETB readnum=0 loadb=1; EXEC loadc=1; WB writenum=2 write=1; 6 edges total.
REQ-037 IR=0xA900 (CMP R1,R0) -> loads=1 in EXEC, write never 1. IR=0xC069 (MOV R3,R1,LSL) -> asel=1, shift=01 in EXEC, writenum=3 in WB.
REQ-038 IR=0xE000 (undefined) -> DECODE returns to WAIT, write=0. load pulsed while w=0 -> IR unchanged.
